// File: rtl/thd_uart_tx_pkg.sv
// Shared constants, state encodings and baud-divisor derivation for the THD UART frame transmitter.
package thd_uart_tx_pkg;

    localparam int unsigned FRAME_LEN   = 7;
    localparam int unsigned IDX_W       = 3;
    localparam logic [7:0]  HEADER_BYTE = 8'hA5;
    localparam logic [2:0]  LAST_IDX    = 3'(FRAME_LEN - 1);

    // Frame sequencer: one LOAD cycle before the first byte, then bytes chain directly.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_SEND
    } seq_state_e;

    // Per-byte serializer.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/thd_uart_tx_byte.sv
// 8N1 byte serializer: baud counter plus start/data/stop shifter with a start/done handshake.
module thd_uart_tx_byte
    import thd_uart_tx_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done_c
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shreg, sh_nxt;
    logic             tx_nxt;
    logic             tick;

    assign tick = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= sh_nxt;
            tx      <= tx_nxt;
        end
    end

    // A start accepted in the last stop-bit cycle chains the next byte with no idle gap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = tick ? '0 : cnt + CNT_W'(1);
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        tx_nxt    = tx;
        done_c    = 1'b0;
        unique case (state)
            TX_IDLE: begin
                cnt_nxt = '0;
                tx_nxt  = 1'b1;
                if (start) begin
                    state_nxt = TX_START;
                    sh_nxt    = data;
                    tx_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_nxt = TX_DATA;
                    bit_nxt   = '0;
                    tx_nxt    = shreg[0];
                end
            end
            TX_DATA: begin
                if (tick) begin
                    sh_nxt = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = TX_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = shreg[1];
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    done_c = 1'b1;
                    if (start) begin
                        state_nxt = TX_START;
                        sh_nxt    = data;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = TX_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = TX_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/thd_uart_tx.sv
// Captures one THD value per analysis frame after catch_flag/source_sop blanking and sends it
// as a 7-byte UART frame: header, five payload bytes MSB first, 8-bit checksum.
module thd_uart_tx
    import thd_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter logic [7:0]  HEADER   = HEADER_BYTE,
    parameter int unsigned DATA_W   = 40
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] thd_in,
    input  logic              catch_flag,
    input  logic              source_sop,
    output logic              uart_tx,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);

    seq_state_e        state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt, byte_sel;
    logic [DATA_W-1:0] shadow, shadow_nxt;
    logic              cf_d, arm, arm_nxt;
    logic              busy_nxt, fd_nxt, ovr_nxt;
    logic              capture_c, accept_c;
    logic              byte_start_c, byte_done_c;
    logic [7:0]        byte_data_c, csum_c;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= SEQ_IDLE;
            idx        <= '0;
            shadow     <= '0;
            cf_d       <= 1'b0;
            arm        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            cf_d       <= catch_flag;
            arm        <= arm_nxt;
            busy       <= busy_nxt;
            frame_done <= fd_nxt;
            overrun    <= ovr_nxt;
        end
    end

    // Capture: arm on catch_flag fall, fire on first unblanked cycle; busy lasts through frame_done.
    always_comb begin
        capture_c  = arm & ~catch_flag & ~source_sop;
        accept_c   = capture_c & ~busy;
        arm_nxt    = arm;
        if (cf_d && !catch_flag) begin
            arm_nxt = 1'b1;
        end else if (capture_c || (catch_flag && !cf_d)) begin
            arm_nxt = 1'b0;
        end
        busy_nxt   = busy;
        if (accept_c) begin
            busy_nxt = 1'b1;
        end else if (frame_done) begin
            busy_nxt = 1'b0;
        end
        ovr_nxt    = capture_c ? busy : overrun;
        shadow_nxt = accept_c ? thd_in : shadow;
    end

    assign csum_c = shadow[39:32] + shadow[31:24] + shadow[23:16] + shadow[15:8] + shadow[7:0];

    always_comb begin
        byte_data_c = csum_c;
        case (byte_sel)
            3'd0:    byte_data_c = HEADER;
            3'd1:    byte_data_c = shadow[39:32];
            3'd2:    byte_data_c = shadow[31:24];
            3'd3:    byte_data_c = shadow[23:16];
            3'd4:    byte_data_c = shadow[15:8];
            3'd5:    byte_data_c = shadow[7:0];
            default: byte_data_c = csum_c;
        endcase
    end

    // Frame sequencer; later bytes are handed over in the last stop-bit cycle of the previous one.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        byte_sel     = idx;
        byte_start_c = 1'b0;
        fd_nxt       = 1'b0;
        unique case (state)
            SEQ_IDLE: begin
                if (accept_c) begin
                    state_nxt = SEQ_LOAD;
                    idx_nxt   = '0;
                end
            end
            SEQ_LOAD: begin
                byte_start_c = 1'b1;
                state_nxt    = SEQ_SEND;
            end
            SEQ_SEND: begin
                if (byte_done_c) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = SEQ_IDLE;
                        idx_nxt   = '0;
                        fd_nxt    = 1'b1;
                    end else begin
                        idx_nxt      = idx + 3'd1;
                        byte_sel     = idx + 3'd1;
                        byte_start_c = 1'b1;
                    end
                end
            end
            default: state_nxt = SEQ_IDLE;
        endcase
    end

    thd_uart_tx_byte #(
        .DIV (BAUD_DIV)
    ) u_byte (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .start  (byte_start_c),
        .data   (byte_data_c),
        .tx     (uart_tx),
        .done_c (byte_done_c)
    );

endmodule

// File: tb/tb_thd_uart_tx.sv
// Self-checking bench for thd_uart_tx: fast-baud instance for frame content/corners,
// default-parameter instance for the 434-cycle bit timing.
module tb_thd_uart_tx;

    localparam int unsigned M_CLK     = 1_600_000;
    localparam int unsigned M_BAUD    = 200_000;
    localparam int          DIV       = 8;
    localparam int          FRAME_CYC = 70 * DIV;

    typedef logic [6:0][7:0] frame_t;
    typedef struct { logic [7:0] data; logic stop; longint t0; } rx_t;
    typedef struct { logic [39:0] thd; int sop_d; logic [7:0] csum; } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [39:0] thd_in, thd_def;
    logic        catch_flag, source_sop, catch_def, sop_def;
    logic        uart_tx, busy, frame_done, overrun;
    logic        tx_def, busy_def, fd_def, ovr_def;

    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    int     fd_cnt = 0;
    longint fd_last = 0;
    rx_t    rx_q[$];

    thd_uart_tx #(.CLK_FREQ(M_CLK), .BAUD(M_BAUD)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .thd_in(thd_in),
        .catch_flag(catch_flag), .source_sop(source_sop), .uart_tx(uart_tx),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    thd_uart_tx dut_def (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .thd_in(thd_def),
        .catch_flag(catch_def), .source_sop(sop_def), .uart_tx(tx_def),
        .busy(busy_def), .frame_done(fd_def), .overrun(ovr_def)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt  <= fd_cnt + 1;
            fd_last <= cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] rand40();
        return {8'($urandom), $urandom};
    endfunction

    // Reference frame: header, big-endian payload bytes, byte sum modulo 256.
    function automatic frame_t build_frame(input logic [39:0] v);
        frame_t f;
        int     sum = 0;
        f[0] = 8'hA5;
        for (int k = 0; k < 5; k++) begin
            f[k+1] = v[39-8*k -: 8];
            sum += int'(f[k+1]);
        end
        f[6] = 8'(sum % 256);
        return f;
    endfunction

    // UART receiver on the fast instance: mid-bit sampling, drops bytes disturbed by reset.
    initial begin : rx_main
        rx_t r;
        bit  ok;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n === 1'b1 && uart_tx === 1'b0) begin
                r.t0 = cyc;
                ok   = 1'b1;
                for (int k = 0; k < DIV / 2; k++) begin
                    @(negedge sys_clk);
                    if (sys_rst_n !== 1'b1) ok = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    for (int k = 0; k < DIV; k++) begin
                        @(negedge sys_clk);
                        if (sys_rst_n !== 1'b1) ok = 1'b0;
                    end
                    r.data[b] = uart_tx;
                end
                for (int k = 0; k < DIV; k++) begin
                    @(negedge sys_clk);
                    if (sys_rst_n !== 1'b1) ok = 1'b0;
                end
                r.stop = uart_tx;
                if (ok) rx_q.push_back(r);
            end
        end
    end

    task automatic drive(input bit to_def, input logic cf, input logic sop, input logic [39:0] v);
        if (to_def) begin
            catch_def = cf; sop_def = sop; thd_def = v;
        end else begin
            catch_flag = cf; source_sop = sop; thd_in = v;
        end
    endtask

    // Catch pulse of 'hi' cycles, source_sop high for 'sop_d' cycles from the fall; val only on capture cycle.
    task automatic capture_pulse(input bit to_def, input int hi, input int sop_d,
                                 input logic [39:0] val, output longint cap);
        for (int j = 0; j < hi; j++) begin
            @(posedge sys_clk); #1; drive(to_def, 1'b1, 1'b0, rand40());
        end
        @(posedge sys_clk); #1; drive(to_def, 1'b0, sop_d > 0, rand40());
        for (int j = 1; j < sop_d; j++) begin
            @(posedge sys_clk); #1; drive(to_def, 1'b0, 1'b1, rand40());
        end
        @(posedge sys_clk); #1; drive(to_def, 1'b0, 1'b0, val);
        cap = cyc;
        @(posedge sys_clk); #1; drive(to_def, 1'b0, 1'b0, rand40());
    endtask

    task automatic wait_until(input longint t);
        while (cyc < t) begin
            @(posedge sys_clk); #1; thd_in = rand40();
        end
    endtask

    // Collect seven bytes while thd_in keeps changing, then check content, spacing and frame_done.
    task automatic wait_frame(input string tag, input longint cap, input int fd0, input frame_t exp);
        rx_t r;
        for (int k = 0; k < FRAME_CYC + 40 && rx_q.size() < 7; k++) begin
            @(posedge sys_clk); #1; thd_in = rand40();
        end
        if (rx_q.size() < 7) begin
            check($sformatf("%s_timeout", tag), 64'(rx_q.size()), 64'd7);
            rx_q.delete();
            return;
        end
        for (int i = 0; i < 7; i++) begin
            r = rx_q.pop_front();
            check($sformatf("%s_byte%0d", tag, i), 64'(r.data), 64'(exp[i]));
            check($sformatf("%s_stop%0d", tag, i), 64'(r.stop), 64'd1);
            check($sformatf("%s_t0_%0d", tag, i), 64'(r.t0), 64'(cap + 2 + i * 10 * DIV));
        end
        for (int k = 0; k < 20 && busy !== 1'b0; k++) @(negedge sys_clk);
        check($sformatf("%s_busy_end", tag), 64'(busy), 64'd0);
        check($sformatf("%s_fd_count", tag), 64'(fd_cnt - fd0), 64'd1);
        check($sformatf("%s_fd_time", tag), 64'(fd_last), 64'(cap + 2 + FRAME_CYC));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t   vt[6];
        frame_t f;
        longint cap, cap2, t_fall, t_rise, t_fd, t0;
        int     fd0;
        logic [39:0] v;

        vt[0] = '{40'h0005F5E100, 0, 8'hDB};
        vt[1] = '{40'hFFFFFFFFFF, 1, 8'hFB};
        vt[2] = '{40'h0000000000, 2, 8'h00};
        vt[3] = '{40'h0102030405, 5, 8'h0F};
        vt[4] = '{40'h8080808080, 3, 8'h80};
        vt[5] = '{40'h123456789A, 0, 8'hAE};

        sys_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        repeat (3) @(negedge sys_clk);
        check("rst_uart_tx", 64'(uart_tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_tx_def", 64'(tx_def), 64'd1);
        @(posedge sys_clk); #1; sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("idle_uart_tx", 64'(uart_tx), 64'd1);

        // Table vectors: known frames with hand-computed checksums and varied sop blanking.
        foreach (vt[i]) begin
            fd0 = fd_cnt;
            capture_pulse(1'b0, 2, vt[i].sop_d, vt[i].thd, cap);
            f = build_frame(vt[i].thd);
            f[6] = vt[i].csum;
            wait_frame($sformatf("vec%0d", i), cap, fd0, f);
            check($sformatf("vec%0d_overrun", i), 64'(overrun), 64'd0);
        end

        // Default-rate timing: latency, start-bit width and full frame length.
        capture_pulse(1'b1, 3, 2, 40'h0005F5E100, cap);
        t_fall = -1; t_rise = -1; t_fd = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (tx_def === 1'b0) begin t_fall = cyc; break; end
        end
        check("def_start_latency", 64'(t_fall - cap), 64'd2);
        for (int k = 0; k < 1000; k++) begin
            @(negedge sys_clk);
            if (tx_def === 1'b1) begin t_rise = cyc; break; end
        end
        check("def_start_width", 64'(t_rise - t_fall), 64'd434);
        for (int k = 0; k < 31000; k++) begin
            @(negedge sys_clk);
            if (fd_def === 1'b1) begin t_fd = cyc; break; end
        end
        check("def_frame_len", 64'(t_fd - t_fall), 64'd30380);
        check("def_busy_at_done", 64'(busy_def), 64'd1);
        @(negedge sys_clk);
        check("def_busy_after", 64'(busy_def), 64'd0);
        check("def_overrun", 64'(ovr_def), 64'd0);

        // Overrun: second capture mid-frame is dropped and flagged.
        v = 40'hDEADBEEF01;
        fd0 = fd_cnt;
        capture_pulse(1'b0, 2, 0, v, cap);
        repeat (100) begin @(posedge sys_clk); #1; thd_in = rand40(); end
        @(negedge sys_clk);
        check("ovr_busy_mid", 64'(busy), 64'd1);
        capture_pulse(1'b0, 3, 1, 40'h1111111111, cap2);
        @(negedge sys_clk);
        check("ovr_set", 64'(overrun), 64'd1);
        wait_frame("ovr_first", cap, fd0, build_frame(v));
        check("ovr_sticky", 64'(overrun), 64'd1);

        // Next accepted frame clears overrun; a capture landing on its frame_done cycle is an overrun.
        v = 40'h00A1B2C3D4;
        fd0 = fd_cnt;
        capture_pulse(1'b0, 1, 0, v, cap);
        @(negedge sys_clk);
        check("ovr_cleared", 64'(overrun), 64'd0);
        wait_until(cap + 2 + FRAME_CYC - 3);
        capture_pulse(1'b0, 1, 0, 40'h5555555555, cap2);
        @(negedge sys_clk);
        check("fd_coincide_overrun", 64'(overrun), 64'd1);
        wait_frame("fd_coincide", cap, fd0, build_frame(v));
        repeat (30) @(negedge sys_clk);
        check("fd_coincide_no_frame", 64'(rx_q.size()), 64'd0);
        check("fd_coincide_idle_tx", 64'(uart_tx), 64'd1);

        // Randomized frames against the reference model.
        for (int n = 0; n < 6; n++) begin
            v = rand40();
            fd0 = fd_cnt;
            capture_pulse(1'b0, int'($urandom_range(1, 4)), int'($urandom_range(0, 6)), v, cap);
            wait_frame($sformatf("rnd%0d", n), cap, fd0, build_frame(v));
            check($sformatf("rnd%0d_overrun", n), 64'(overrun), 64'd0);
        end

        // Reset during the data bits of byte 3: line idles at once, nothing resumes.
        fd0 = fd_cnt;
        capture_pulse(1'b0, 2, 0, 40'h0F0F0F0F0F, cap);
        t0 = cap + 2;
        wait_until(t0 + 30 * DIV + DIV + 3 * DIV);
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_uart_tx", 64'(uart_tx), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge sys_clk);
        #1; sys_rst_n = 1'b1;
        repeat (12 * DIV) @(negedge sys_clk);
        check("rst_mid_no_done", 64'(fd_cnt - fd0), 64'd0);
        check("rst_mid_line_idle", 64'(uart_tx), 64'd1);
        rx_q.delete();
        v = 40'h7E57C0FFEE;
        fd0 = fd_cnt;
        capture_pulse(1'b0, 2, 1, v, cap);
        wait_frame("post_rst", cap, fd0, build_frame(v));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
